// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Interface : fetch_if
// Instruction-memory request/response bus between fetch (master) and imem.
// Revision  : 1.0
// ============================================================================
interface fetch_if;
    logic        rden;
    logic [31:0] addr;
    logic        ready;
    logic        valid;
    logic [31:0] data;

    modport master (
        output rden,
        output addr,
        input  ready,
        input  valid,
        input  data
    );

    modport slave (
        input  rden,
        input  addr,
        output ready,
        output valid,
        output data
    );
endinterface
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// In-order instruction fetch with credit-limited issue, DEPTH-entry buffer and
// flush-time dropping of in-flight responses. Optional FETCH_JAL_PRED_EN macro
// redirects fetch on a buffered JAL.
// Revision : 1.0
// ============================================================================
module fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        flush_i,
    input  wire logic [31:0] new_pc_i,
    input  wire logic        stall_i,
    output logic             mem_wait_o,
    output logic [31:0]      inst_pc_o,
    output logic [31:0]      inst_data_o,
    fetch_if.master          imem
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic [CW:0]   w_credit_used;
    logic          w_accept;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_jal;
    logic [31:0]   w_jal_target;
    logic [31:0]   w_new_pc;

    // Requests in flight plus buffered words can never exceed the buffer size.
    assign w_credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem.rden     = !rst && !flush_i && (w_credit_used < CREDITS);
    assign imem.addr     = pc_q;

    assign w_accept      = imem.rden && imem.ready;
    assign w_drop        = imem.valid && (drop_q != '0);
    assign w_push        = imem.valid && (drop_q == '0) && !flush_i;
    assign w_pop         = (count_q != '0) && !stall_i;
    assign outstanding_d = outstanding_q + {{PW{1'b0}}, w_accept} - {{PW{1'b0}}, imem.valid};
    assign w_new_pc      = new_pc_i & ~32'h3;

`ifdef FETCH_JAL_PRED_EN
    assign w_jal        = w_push && (imem.data[6:0] == 7'b1101111);
    assign w_jal_target = resp_pc_q + {{11{imem.data[31]}}, imem.data[31], imem.data[19:12],
                                       imem.data[20], imem.data[30:21], 1'b0};
`else
    assign w_jal        = 1'b0;
    assign w_jal_target = resp_pc_q;
`endif

    assign mem_wait_o  = (count_q == '0);
    assign inst_pc_o   = mem_wait_o ? 32'h0 : pc_mem_q[rd_ptr_q];
    assign inst_data_o = mem_wait_o ? 32'h0 : data_mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            // Everything still in flight (including a response landing now) is discarded.
            pc_q          <= w_new_pc;
            resp_pc_q     <= w_new_pc;
            outstanding_q <= outstanding_d;
            drop_q        <= outstanding_d;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            count_q       <= count_q + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
            if (w_accept)
                pc_q <= pc_q + 32'd4;
            if (w_drop)
                drop_q <= drop_q - {{PW{1'b0}}, 1'b1};
            if (w_push) begin
                pc_mem_q[wr_ptr_q]   <= resp_pc_q;
                data_mem_q[wr_ptr_q] <= imem.data;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
                resp_pc_q            <= resp_pc_q + 32'd4;
            end
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            if (w_jal) begin
                pc_q      <= w_jal_target;
                resp_pc_q <= w_jal_target;
                drop_q    <= outstanding_d;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Testbench : tb_fetch
// Directed scenarios then random traffic against an in-order memory model and
// an expected-PC-stream reference for the fetch stage.
// Revision  : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic        mem_wait;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    fetch_if bus();

    fetch #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .new_pc_i    (new_pc),
        .stall_i     (stall),
        .mem_wait_o  (mem_wait),
        .inst_pc_o   (inst_pc),
        .inst_data_o (inst_data),
        .imem        (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t        q[$];
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    bit          hold = 1'b0;
    int          n_pops = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        s_mw, s_rden, s_valid;
    logic [31:0] s_pc, s_data, s_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] w;
        w = {a[26:2] ^ 25'h0F0F0F0, 7'h13};
        if (a == 32'h20) w = 32'h0100006F;
        return w;
    endfunction

    // Decode sees a straight-line stream; with prediction a JAL +16 jumps ahead.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] word);
        logic [31:0] n;
        n = pc + 32'd4;
`ifdef FETCH_JAL_PRED_EN
        if (word == 32'h0100006F) n = pc + 32'd16;
`else
        if (word == 32'hFFFF_FFFF) n = pc + 32'd4;
`endif
        return n;
    endfunction

    task automatic tick();
        int due;
        @(negedge clk);
        bus.valid = 1'b0;
        bus.data  = 32'h0;
        if (q.size() > 0 && q[0].due <= cyc && !hold) begin
            bus.valid = 1'b1;
            bus.data  = memword(q[0].addr);
        end
        #1;
        s_mw = mem_wait; s_pc = inst_pc; s_data = inst_data;
        s_rden = bus.rden; s_addr = bus.addr; s_valid = bus.valid;
        if (flush) begin
            check("rden_in_flush", {31'b0, s_rden}, 32'd0);
            exp_pc   = new_pc & ~32'h3;
            exp_addr = exp_pc;
        end else begin
            if (s_mw) begin
                check("empty_pc", s_pc, 32'h0);
                check("empty_data", s_data, 32'h0);
            end else begin
                check("head_pc", s_pc, exp_pc);
                check("head_data", s_data, memword(exp_pc));
                if (!stall) begin
                    exp_pc = next_pc(exp_pc, memword(exp_pc));
                    n_pops++;
                end
            end
            if (s_rden && bus.ready) begin
`ifndef FETCH_JAL_PRED_EN
                check("issue_addr", s_addr, exp_addr);
`endif
                exp_addr = s_addr + 32'd4;
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                q.push_back('{s_addr, due});
                last_due = due;
            end
        end
        if (s_valid) void'(q.pop_front());
        check("credit", {31'b0, q.size() <= DEPTH}, 32'd1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_async_mw", {31'b0, mem_wait}, 32'd1);
        flush = 1'b0; stall = 1'b0; hold = 1'b0;
        bus.ready = 1'b0; bus.valid = 1'b0; bus.data = 32'h0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_pc", inst_pc, 32'h0);
        check("rst_data", inst_data, 32'h0);
        check("rst_rden", {31'b0, bus.rden}, 32'd0);
        check("rst_addr", bus.addr, RV);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_due = cyc;
        exp_pc = RV;
        exp_addr = RV;
    endtask

    task automatic wait_head(input string tag, input logic [31:0] want);
        int n;
        n = 0;
        stall = 1'b1;
        tick();
        while (s_mw && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, {31'b0, s_mw}, 32'd0);
        check(tag, s_pc, want);
        stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p0, a0;
        bus.ready = 1'b0; bus.valid = 1'b0; bus.data = 32'h0;
        do_reset();

        // Straight-line fetch, 1-cycle memory.
        lat = 1; bus.ready = 1'b1;
        tick(); check("p1_wait0", {31'b0, s_mw}, 32'd1); check("p1_addr0", s_addr, 32'h0);
        tick(); check("p1_wait1", {31'b0, s_mw}, 32'd1); check("p1_addr1", s_addr, 32'h4);
        tick(); check("p1_wait2", {31'b0, s_mw}, 32'd0); check("p1_pc0", s_pc, 32'h0);
        tick(); check("p1_pc1", s_pc, 32'h4);
        tick(); check("p1_pc2", s_pc, 32'h8);
        repeat (4) tick();

        // Stall fills the buffer until credits run out.
        stall = 1'b1;
        tick(); p0 = s_pc;
        tick(); check("p2_hold", s_pc, p0);
        tick(); check("p2_hold2", s_pc, p0); check("p2_rden_off", {31'b0, s_rden}, 32'd0);
        stall = 1'b0;
        repeat (6) tick();

        // Memory not ready: address holds, buffer drains.
        bus.ready = 1'b0;
        tick(); a0 = s_addr;
        repeat (4) begin tick(); check("p3_addr_stable", s_addr, a0); end
        check("p3_drained", {31'b0, s_mw}, 32'd1);
        bus.ready = 1'b1;
        repeat (8) tick();

        // Flush coinciding with a returning response at full credit.
        stall = 1'b1;
        tick(); tick();
        flush = 1'b1; new_pc = 32'h200;
        tick(); check("p5_valid_in_flush", {31'b0, s_valid}, 32'd1);
        flush = 1'b0; stall = 1'b0;
        tick(); check("p5_empty_after", {31'b0, s_mw}, 32'd1);
        repeat (6) tick();

        // 3-cycle memory, flush with requests in flight.
        lat = 3;
        repeat (10) tick();
        check("p4_inflight", {31'b0, q.size() >= 2}, 32'd1);
        flush = 1'b1; new_pc = 32'h103;
        tick();
        flush = 1'b0;
        wait_head("p4_head", 32'h100);
        repeat (6) tick();

        // JAL word at 0x20.
        lat = 1;
        flush = 1'b1; new_pc = 32'h1C;
        tick();
        flush = 1'b0;
        wait_head("p6_a", 32'h1C);
        tick();
        wait_head("p6_b", 32'h20);
        tick();
`ifdef FETCH_JAL_PRED_EN
        wait_head("p6_c", 32'h30);
`else
        wait_head("p6_c", 32'h24);
`endif

        // Asynchronous mid-run reset, then random traffic.
        #3;
        do_reset();
        n_pops = 0;
        for (int i = 0; i < 600; i++) begin
            bus.ready = ($urandom % 4) != 0;
            stall     = ($urandom % 10) < 3;
            hold      = ($urandom % 5) == 0;
            lat       = 1 + ($urandom % 3);
            flush     = ($urandom % 40) == 0;
            new_pc    = $urandom_range(0, 32'h3FF);
            tick();
        end
        flush = 1'b0; stall = 1'b0; hold = 1'b0;
        check("rand_progress", {31'b0, n_pops > 100}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
